// File: rtl/stack_ptr_unit.sv
// Data-stack and return-stack pointer unit: applies push/pop commands from the
// control unit, tracks depth and sticky errors, and muxes the memory address.
module stack_ptr_unit #(
   parameter int             AW       = 16,
   parameter int             STEP     = 2,
   parameter logic [AW-1:0]  DS_BASE  = 16'hFFFC,
   parameter logic [AW-1:0]  RS_BASE  = 16'hEFFC,
   parameter int             DS_DEPTH = 64,
   parameter int             RS_DEPTH = 64
) (
   input  logic                          CLK,
   input  logic                          reset,
   input  logic [1:0]                    dp_inc,
   input  logic [1:0]                    rp_inc,
   input  logic [1:0]                    mem_addr,
   input  logic                          clr_err,
   input  logic [AW-1:0]                 pc,
   input  logic [AW-1:0]                 tr,
   output logic [AW-1:0]                 addr,
   output logic [AW-1:0]                 dp,
   output logic [AW-1:0]                 rp,
   output logic [$clog2(DS_DEPTH+1)-1:0] ds_depth,
   output logic [$clog2(RS_DEPTH+1)-1:0] rs_depth,
   output logic                          ds_empty,
   output logic                          ds_full,
   output logic                          rs_empty,
   output logic                          rs_full,
   output logic                          ds_ovf,
   output logic                          ds_unf,
   output logic                          rs_ovf,
   output logic                          rs_unf,
   output logic                          illegal
);

   localparam int DSW = $clog2(DS_DEPTH+1);
   localparam int RSW = $clog2(RS_DEPTH+1);

   localparam logic [AW-1:0]  STEP_W    = AW'(STEP);
   localparam logic [DSW-1:0] DS_MAXCNT = DSW'(DS_DEPTH);
   localparam logic [RSW-1:0] RS_MAXCNT = RSW'(RS_DEPTH);

   localparam logic [1:0] CMD_PUSH = 2'b01;
   localparam logic [1:0] CMD_POP  = 2'b10;
   localparam logic [1:0] CMD_ILL  = 2'b11;

   localparam logic [1:0] SEL_PC = 2'b00;
   localparam logic [1:0] SEL_DP = 2'b01;
   localparam logic [1:0] SEL_RP = 2'b10;

   logic [AW-1:0]  dsPtr_q, dsPtr_d;
   logic [AW-1:0]  rsPtr_q, rsPtr_d;
   logic [DSW-1:0] dsDepth_q, dsDepth_d;
   logic [RSW-1:0] rsDepth_q, rsDepth_d;
   logic           dsOvf_q, dsOvf_d, dsUnf_q, dsUnf_d;
   logic           rsOvf_q, rsOvf_d, rsUnf_q, rsUnf_d;
   logic           illegal_q, illegal_d;

   // Data stack grows down; bounds come only from the depth count, so the
   // pointer itself simply wraps modulo 2^AW.
   always_comb begin
      dsPtr_d   = dsPtr_q;
      dsDepth_d = dsDepth_q;
      dsOvf_d   = clr_err ? 1'b0 : dsOvf_q;
      dsUnf_d   = clr_err ? 1'b0 : dsUnf_q;
      case (dp_inc)
         CMD_PUSH: begin
            if (dsDepth_q == DS_MAXCNT) begin
               dsOvf_d = 1'b1;
            end else begin
               dsPtr_d   = dsPtr_q - STEP_W;
               dsDepth_d = dsDepth_q + DSW'(1);
            end
         end
         CMD_POP: begin
            if (dsDepth_q == '0) begin
               dsUnf_d = 1'b1;
            end else begin
               dsPtr_d   = dsPtr_q + STEP_W;
               dsDepth_d = dsDepth_q - DSW'(1);
            end
         end
         default: ;
      endcase
   end

   // Return stack behaves identically and independently of the data stack.
   always_comb begin
      rsPtr_d   = rsPtr_q;
      rsDepth_d = rsDepth_q;
      rsOvf_d   = clr_err ? 1'b0 : rsOvf_q;
      rsUnf_d   = clr_err ? 1'b0 : rsUnf_q;
      case (rp_inc)
         CMD_PUSH: begin
            if (rsDepth_q == RS_MAXCNT) begin
               rsOvf_d = 1'b1;
            end else begin
               rsPtr_d   = rsPtr_q - STEP_W;
               rsDepth_d = rsDepth_q + RSW'(1);
            end
         end
         CMD_POP: begin
            if (rsDepth_q == '0) begin
               rsUnf_d = 1'b1;
            end else begin
               rsPtr_d   = rsPtr_q + STEP_W;
               rsDepth_d = rsDepth_q - RSW'(1);
            end
         end
         default: ;
      endcase
   end

   // A fresh error in the same cycle as clr_err keeps the flag set.
   always_comb begin
      illegal_d = (clr_err ? 1'b0 : illegal_q)
                | (dp_inc == CMD_ILL) | (rp_inc == CMD_ILL);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         dsPtr_q   <= DS_BASE + STEP_W;
         rsPtr_q   <= RS_BASE + STEP_W;
         dsDepth_q <= '0;
         rsDepth_q <= '0;
         dsOvf_q   <= 1'b0;
         dsUnf_q   <= 1'b0;
         rsOvf_q   <= 1'b0;
         rsUnf_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         dsPtr_q   <= dsPtr_d;
         rsPtr_q   <= rsPtr_d;
         dsDepth_q <= dsDepth_d;
         rsDepth_q <= rsDepth_d;
         dsOvf_q   <= dsOvf_d;
         dsUnf_q   <= dsUnf_d;
         rsOvf_q   <= rsOvf_d;
         rsUnf_q   <= rsUnf_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      case (mem_addr)
         SEL_PC:  addr = pc;
         SEL_DP:  addr = dsPtr_q;
         SEL_RP:  addr = rsPtr_q;
         default: addr = tr;
      endcase
   end

   assign dp       = dsPtr_q;
   assign rp       = rsPtr_q;
   assign ds_depth = dsDepth_q;
   assign rs_depth = rsDepth_q;
   assign ds_empty = (dsDepth_q == '0);
   assign ds_full  = (dsDepth_q == DS_MAXCNT);
   assign rs_empty = (rsDepth_q == '0);
   assign rs_full  = (rsDepth_q == RS_MAXCNT);
   assign ds_ovf   = dsOvf_q;
   assign ds_unf   = dsUnf_q;
   assign rs_ovf   = rsOvf_q;
   assign rs_unf   = rsUnf_q;
   assign illegal  = illegal_q;

endmodule
